// File: rtl/button_pkg.sv
// Shared definitions for the button conditioner: repeat-state encoding,
// default strobe counts and a counter-width helper.
package button_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE  = 2'd0,
    RPT_DELAY = 2'd1,
    RPT_RATE  = 2'd2
  } rpt_state_t;

  localparam int DEF_NUM_SAMPLES  = 5;
  localparam int DEF_REPEAT_DELAY = 2048;
  localparam int DEF_REPEAT_RATE  = 410;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_conditioner_ch.sv
// One button channel: 2-flop synchroniser, hysteresis debounce, edge pulses
// and hold-to-repeat FSM, all paced by the shared debounce strobe.
module button_conditioner_ch
  import button_pkg::*;
#(
  parameter int NUM_SAMPLES  = DEF_NUM_SAMPLES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_debounce_stb,
  input  logic i_button,
  input  logic i_repeat_en,
  output logic o_db,
  output logic o_press,
  output logic o_release,
  output logic o_repeat,
  output logic o_step
);

  localparam int CNT_W  = count_width(NUM_SAMPLES);
  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RC_W   = count_width(RC_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(NUM_SAMPLES - 1);
  localparam logic [RC_W-1:0]  DELAY_LAST = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0]  RATE_LAST  = RC_W'(REPEAT_RATE - 1);

  logic             meta_reg, sync_reg;
  logic             db_reg, db_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             press_reg, release_reg, repeat_reg, step_reg;
  logic             press_next, release_next, repeat_next;
  rpt_state_t       state_reg, state_next;
  logic [RC_W-1:0]  rc_reg, rc_next;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta_reg    <= 1'b0;
      sync_reg    <= 1'b0;
      db_reg      <= 1'b0;
      cnt_reg     <= '0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      repeat_reg  <= 1'b0;
      step_reg    <= 1'b0;
      state_reg   <= RPT_IDLE;
      rc_reg      <= '0;
    end else begin
      meta_reg    <= i_button;
      sync_reg    <= meta_reg;
      db_reg      <= db_next;
      cnt_reg     <= cnt_next;
      press_reg   <= press_next;
      release_reg <= release_next;
      repeat_reg  <= repeat_next;
      step_reg    <= press_next | repeat_next;
      state_reg   <= state_next;
      rc_reg      <= rc_next;
    end
  end

  always_comb begin
    db_next  = db_reg;
    cnt_next = cnt_reg;
    if (i_debounce_stb) begin
      if (sync_reg == db_reg) begin
        cnt_next = '0;
      end else if (cnt_reg == CNT_LAST) begin
        db_next  = sync_reg;
        cnt_next = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
    press_next   = db_next & ~db_reg;
    release_next = ~db_next & db_reg;
  end

  // Exit test uses db_next so a release on the same strobe cancels a due repeat.
  always_comb begin
    state_next  = state_reg;
    rc_next     = rc_reg;
    repeat_next = 1'b0;
    if (!db_next || !i_repeat_en) begin
      state_next = RPT_IDLE;
      rc_next    = '0;
    end else begin
      case (state_reg)
        RPT_IDLE: begin
          if (press_next) begin
            state_next = RPT_DELAY;
            rc_next    = '0;
          end
        end
        RPT_DELAY: begin
          if (i_debounce_stb) begin
            if (rc_reg == DELAY_LAST) begin
              repeat_next = 1'b1;
              rc_next     = '0;
              state_next  = RPT_RATE;
            end else begin
              rc_next = rc_reg + 1'b1;
            end
          end
        end
        RPT_RATE: begin
          if (i_debounce_stb) begin
            if (rc_reg == RATE_LAST) begin
              repeat_next = 1'b1;
              rc_next     = '0;
            end else begin
              rc_next = rc_reg + 1'b1;
            end
          end
        end
        default: begin
          state_next = RPT_IDLE;
          rc_next    = '0;
        end
      endcase
    end
  end

  assign o_db      = db_reg;
  assign o_press   = press_reg;
  assign o_release = release_reg;
  assign o_repeat  = repeat_reg;
  assign o_step    = step_reg;

endmodule

// File: rtl/button_conditioner.sv
// N-channel button front end: one independent conditioner per raw button,
// sharing the clock, reset and debounce strobe.
module button_conditioner
  import button_pkg::*;
#(
  parameter int NUM_CH       = 3,
  parameter int NUM_SAMPLES  = DEF_NUM_SAMPLES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_debounce_stb,
  input  logic [NUM_CH-1:0] i_buttons,
  input  logic [NUM_CH-1:0] i_repeat_en,
  output logic [NUM_CH-1:0] o_db,
  output logic [NUM_CH-1:0] o_press,
  output logic [NUM_CH-1:0] o_release,
  output logic [NUM_CH-1:0] o_repeat,
  output logic [NUM_CH-1:0] o_step
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    button_conditioner_ch #(
      .NUM_SAMPLES  (NUM_SAMPLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_ch (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .i_debounce_stb (i_debounce_stb),
      .i_button       (i_buttons[gi]),
      .i_repeat_en    (i_repeat_en[gi]),
      .o_db           (o_db[gi]),
      .o_press        (o_press[gi]),
      .o_release      (o_release[gi]),
      .o_repeat       (o_repeat[gi]),
      .o_step         (o_step[gi])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: stimulus queues expected pulse
// events tagged with the strobe index; a negedge monitor pops and compares.
module tb_button_conditioner;

  localparam int NCH = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           stb;
  logic [NCH-1:0] buttons;
  logic [NCH-1:0] rpt_en;
  logic [NCH-1:0] db, press, rel, rpt, step;

  typedef struct {
    int             stb;
    logic [NCH-1:0] db;
    logic [NCH-1:0] press;
    logic [NCH-1:0] rel;
    logic [NCH-1:0] rpt;
    logic [NCH-1:0] step;
  } evt_t;

  evt_t exp_q[$];
  int   stb_cnt  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  button_conditioner #(
    .NUM_CH       (NCH),
    .NUM_SAMPLES  (5),
    .REPEAT_DELAY (8),
    .REPEAT_RATE  (2)
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_debounce_stb (stb),
    .i_buttons      (buttons),
    .i_repeat_en    (rpt_en),
    .o_db           (db),
    .o_press        (press),
    .o_release      (rel),
    .o_repeat       (rpt),
    .o_step         (step)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe every 4th clock; three idle cycles first let a new button level sync.
  task automatic do_strobes(input int n);
    repeat (n) begin
      tick();
      tick();
      tick();
      stb = 1'b1;
      tick();
      stb = 1'b0;
      stb_cnt++;
    end
  endtask

  task automatic expect_evt(input int k, input logic [NCH-1:0] d, input logic [NCH-1:0] p,
                            input logic [NCH-1:0] r, input logic [NCH-1:0] q);
    evt_t e;
    e.stb   = stb_cnt + k;
    e.db    = d;
    e.press = p;
    e.rel   = r;
    e.rpt   = q;
    e.step  = p | q;
    exp_q.push_back(e);
  endtask

  task automatic check3(input string name, input logic [NCH-1:0] got, input logic [NCH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check3({tag, "_db"}, db, 3'b000);
    check3({tag, "_press"}, press, 3'b000);
    check3({tag, "_release"}, rel, 3'b000);
    check3({tag, "_repeat"}, rpt, 3'b000);
    check3({tag, "_step"}, step, 3'b000);
  endtask

  always @(negedge clk) begin
    evt_t e;
    if ((press | rel | rpt | step) != '0) begin
      n_checks++;
      $display("evt stb=%0d db=%b press=%b rel=%b rpt=%b step=%b", stb_cnt, db, press, rel, rpt, step);
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got stb=%0d press=%b rel=%b rpt=%b step=%b, expected no event",
                 stb_cnt, press, rel, rpt, step);
      end else begin
        e = exp_q.pop_front();
        if (e.stb != stb_cnt || e.db !== db || e.press !== press || e.rel !== rel ||
            e.rpt !== rpt || e.step !== step) begin
          n_fail++;
          $display("FAIL event: got stb=%0d db=%b press=%b rel=%b rpt=%b step=%b, expected stb=%0d db=%b press=%b rel=%b rpt=%b step=%b",
                   stb_cnt, db, press, rel, rpt, step, e.stb, e.db, e.press, e.rel, e.rpt, e.step);
        end
      end
    end
  end

  initial begin
    rst     = 1'b1;
    stb     = 1'b0;
    buttons = '0;
    rpt_en  = '0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;

    // 1: three-strobe glitch is rejected
    buttons = 3'b001;
    do_strobes(3);
    buttons = 3'b000;
    do_strobes(3);
    check3("glitch_db", db, 3'b000);

    // 2: clean press flips on the 5th strobe
    buttons = 3'b001;
    expect_evt(5, 3'b001, 3'b001, 3'b000, 3'b000);
    do_strobes(6);
    check3("press_db", db, 3'b001);

    // 3: 4-strobe release bounce ignored, then real release
    buttons = 3'b000;
    do_strobes(4);
    buttons = 3'b001;
    do_strobes(2);
    check3("bounce_db", db, 3'b001);
    buttons = 3'b000;
    expect_evt(5, 3'b000, 3'b000, 3'b001, 3'b000);
    do_strobes(6);
    check3("release_db", db, 3'b000);

    // 4: repeat on ch1; release lands on a repeat-due strobe and wins
    rpt_en  = 3'b010;
    buttons = 3'b010;
    expect_evt(5, 3'b010, 3'b010, 3'b000, 3'b000);
    for (int k = 13; k <= 21; k += 2) expect_evt(k, 3'b010, 3'b000, 3'b000, 3'b010);
    expect_evt(23, 3'b000, 3'b000, 3'b010, 3'b000);
    do_strobes(18);
    buttons = 3'b000;
    do_strobes(11);
    check3("repeat_db", db, 3'b000);

    // 5: reset while ch1 sits in RATE, then re-detection of held button
    buttons = 3'b010;
    expect_evt(5, 3'b010, 3'b010, 3'b000, 3'b000);
    expect_evt(13, 3'b010, 3'b000, 3'b000, 3'b010);
    do_strobes(14);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midreset");
    expect_evt(5, 3'b010, 3'b010, 3'b000, 3'b000);
    expect_evt(11, 3'b000, 3'b000, 3'b010, 3'b000);
    do_strobes(6);
    buttons = 3'b000;
    do_strobes(5);
    check3("rearm_db", db, 3'b000);

    // 6: ch0+ch2 together; ch2 enable rising while held must not start repeat
    rpt_en  = 3'b011;
    buttons = 3'b101;
    expect_evt(5, 3'b101, 3'b101, 3'b000, 3'b000);
    expect_evt(13, 3'b101, 3'b000, 3'b000, 3'b001);
    expect_evt(15, 3'b101, 3'b000, 3'b000, 3'b001);
    expect_evt(17, 3'b101, 3'b000, 3'b000, 3'b001);
    expect_evt(19, 3'b101, 3'b000, 3'b000, 3'b001);
    expect_evt(21, 3'b000, 3'b000, 3'b101, 3'b000);
    do_strobes(10);
    check3("multi_db", db, 3'b101);
    rpt_en = 3'b111;
    do_strobes(6);
    buttons = 3'b000;
    do_strobes(11);
    check3("multi_release_db", db, 3'b000);

    repeat (4) tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: got %0d events outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
